// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D cache memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    FILL,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    CLI_I,
    CLI_D
  } client_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-client round-robin pick with the last-grant history flop.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_i_i,
  input  logic    req_d_i,
  input  logic    update_i,
  output client_t grant_o
);

  client_t last_q;

  // On a tie the client that did not win last time is picked.
  always_comb begin
    grant_o = CLI_I;
    if (req_i_i && req_d_i) begin
      grant_o = (last_q == CLI_I) ? CLI_D : CLI_I;
    end else if (req_d_i) begin
      grant_o = CLI_D;
    end
  end

  // Remember who was granted; reset history favours D on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= CLI_I;
    end else if (update_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the I-cache and D-cache.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic             d_req,
  input  logic             i_we,
  input  logic             d_we,
  input  logic [15:0]      i_addr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      i_wdata,
  input  logic [15:0]      d_wdata,
  output logic [15:0]      i_rdata,
  output logic [15:0]      d_rdata,
  output logic             i_rvalid,
  output logic             d_rvalid,
  output logic [OFF_W-1:0] i_roff,
  output logic [OFF_W-1:0] d_roff,
  output logic             i_done,
  output logic             d_done,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_rdata_valid,
  input  logic             mem_wdone
);

  localparam logic [OFF_W:0] CNT_FULL = (OFF_W+1)'(LINE_WORDS);
  localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(LINE_WORDS - 1);

  state_t         state_q, state_d;
  client_t        owner_q, owner_d;
  logic           we_q, we_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [OFF_W:0] issue_q, issue_d;
  logic [OFF_W:0] ret_q, ret_d;
  client_t        pick;
  logic           grant_en;
  logic           fill_issue;
  logic           wr_act;
  logic           rv;

  arb_rr2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i_i  (i_req),
    .req_d_i  (d_req),
    .update_i (grant_en),
    .grant_o  (pick)
  );

  // Transaction sequencing: grant, issue/count fill words or hold a write.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    issue_d  = issue_q;
    ret_d    = ret_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_en = 1'b1;
          owner_d  = pick;
          we_d     = (pick == CLI_D) ? d_we    : i_we;
          addr_d   = (pick == CLI_D) ? d_addr  : i_addr;
          wdata_d  = (pick == CLI_D) ? d_wdata : i_wdata;
          issue_d  = '0;
          ret_d    = '0;
          state_d  = GRANT;
        end
      end
      GRANT: state_d = we_q ? WRITE : FILL;
      FILL: begin
        if (issue_q < CNT_FULL) begin
          issue_d = issue_q + 1'b1;
        end
        // Completion is counted in returned words, not cycles.
        if (mem_rdata_valid) begin
          ret_d = ret_q + 1'b1;
          if (ret_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (mem_wdone) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= CLI_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

  // Memory-side strobes and client-side routing, all decoded from state.
  always_comb begin
    fill_issue = (state_q == FILL) && (issue_q < CNT_FULL);
    wr_act     = (state_q == WRITE);
    rv         = (state_q == FILL) && mem_rdata_valid;
    mem_en     = fill_issue || wr_act;
    mem_wr     = wr_act;
    mem_addr   = '0;
    if (wr_act) begin
      mem_addr = addr_q;
    end else if (fill_issue) begin
      mem_addr = {addr_q[15:OFF_W+1], issue_q[OFF_W-1:0], 1'b0};
    end
    mem_wdata = wr_act ? wdata_q : '0;
    i_rvalid  = rv && (owner_q == CLI_I);
    d_rvalid  = rv && (owner_q == CLI_D);
    i_rdata   = i_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
    i_roff    = i_rvalid ? ret_q[OFF_W-1:0] : '0;
    d_roff    = d_rvalid ? ret_q[OFF_W-1:0] : '0;
    i_done    = (state_q == DONE) && (owner_q == CLI_I);
    d_done    = (state_q == DONE) && (owner_q == CLI_D);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, i_we, d_we;
  logic [15:0] i_addr, d_addr, i_wdata, d_wdata;
  logic [15:0] i_rdata, d_rdata;
  logic        i_rvalid, d_rvalid;
  logic [2:0]  i_roff, d_roff;
  logic        i_done, d_done;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rdata_valid, mem_wdone;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req           (i_req),
    .d_req           (d_req),
    .i_we            (i_we),
    .d_we            (d_we),
    .i_addr          (i_addr),
    .d_addr          (d_addr),
    .i_wdata         (i_wdata),
    .d_wdata         (d_wdata),
    .i_rdata         (i_rdata),
    .d_rdata         (d_rdata),
    .i_rvalid        (i_rvalid),
    .d_rvalid        (d_rvalid),
    .i_roff          (i_roff),
    .d_roff          (d_roff),
    .i_done          (i_done),
    .d_done          (d_done),
    .mem_en          (mem_en),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_wdone       (mem_wdone)
  );

  // Memory model: each read issue returns addr^5A5A four cycles later.
  logic        pv [4] = '{default: 1'b0};
  logic [15:0] pa [4] = '{default: 16'h0};
  logic        s_v = 1'b0;
  logic [15:0] s_a = 16'h0;
  logic        model_v = 1'b0;
  logic [15:0] model_d = 16'h0;
  logic        stray_v = 1'b0;
  logic [15:0] stray_d = 16'h0;

  always @(negedge clk) begin
    s_v = mem_en && !mem_wr;
    s_a = mem_addr;
  end

  always @(posedge clk) begin
    for (int j = 3; j > 0; j--) begin
      pv[j] = pv[j-1];
      pa[j] = pa[j-1];
    end
    pv[0] = s_v;
    pa[0] = s_a;
    #1;
    model_v = pv[3];
    model_d = pa[3] ^ 16'h5A5A;
  end

  assign mem_rdata_valid = model_v | stray_v;
  assign mem_rdata       = model_v ? model_d : stray_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_en"}, mem_en, 0);
    chk({tag, ".mem_wr"}, mem_wr, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".i_rvalid"}, i_rvalid, 0);
    chk({tag, ".d_rvalid"}, d_rvalid, 0);
    chk({tag, ".i_rdata"}, i_rdata, 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
    chk({tag, ".i_roff"}, i_roff, 0);
    chk({tag, ".d_roff"}, d_roff, 0);
    chk({tag, ".i_done"}, i_done, 0);
    chk({tag, ".d_done"}, d_done, 0);
  endtask

  // Serve one pending write from client c; wdone is returned on the first write cycle.
  task automatic run_write(input client_t c, input logic [15:0] ea, input logic [15:0] ed,
                           input bit drop, input string tag);
    bit seen = 0;
    bit got  = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (mem_en && mem_wr && !seen) begin
        seen = 1;
        chk({tag, ".addr"}, mem_addr, ea);
        chk({tag, ".wdata"}, mem_wdata, ed);
      end
      mem_wdone = mem_en && mem_wr;
      if ((c == CLI_I) ? i_done : d_done) begin
        got = 1;
        chk({tag, ".other_done"}, (c == CLI_I) ? d_done : i_done, 0);
        if (drop) begin
          if (c == CLI_I) i_req = 1'b0;
          else            d_req = 1'b0;
        end
      end
    end
    chk({tag, ".write_seen"}, seen, 1);
    chk({tag, ".done_seen"}, got, 1);
  endtask

  initial begin
    int  cnt;
    bit  got;
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; i_we = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    mem_wdone = 1'b0;

    // Reset state.
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Simultaneous writes from reset: D first, then alternation.
    i_we = 1'b1; i_addr = 16'h1000; i_wdata = 16'h1111;
    d_we = 1'b1; d_addr = 16'h2000; d_wdata = 16'h2222;
    i_req = 1'b1; d_req = 1'b1;
    run_write(CLI_D, 16'h2000, 16'h2222, 1'b0, "tie1_D");
    run_write(CLI_I, 16'h1000, 16'h1111, 1'b1, "tie2_I");
    run_write(CLI_D, 16'h2000, 16'h2222, 1'b1, "solo_D");
    @(negedge clk);
    i_req = 1'b1; d_req = 1'b1;
    run_write(CLI_I, 16'h1000, 16'h1111, 1'b1, "tie3_I");
    run_write(CLI_D, 16'h2000, 16'h2222, 1'b1, "tie3_D");

    // I fill at 0x5678 with a D write raised mid-fill.
    i_we = 1'b0; i_addr = 16'h5678;
    d_we = 1'b1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      chk($sformatf("fill.c%0d.mem_en", k), mem_en, ((k >= 2 && k <= 9) || (k >= 17 && k <= 19)));
      chk($sformatf("fill.c%0d.mem_wr", k), mem_wr, (k >= 17 && k <= 19));
      if (k >= 2 && k <= 9)
        chk($sformatf("fill.c%0d.mem_addr", k), mem_addr, 32'h5670 + 2 * (k - 2));
      if (k >= 17 && k <= 19) begin
        chk($sformatf("wr.c%0d.mem_addr", k), mem_addr, 32'h0042);
        chk($sformatf("wr.c%0d.mem_wdata", k), mem_wdata, 32'hBEEF);
      end
      chk($sformatf("fill.c%0d.i_rvalid", k), i_rvalid, (k >= 6 && k <= 13));
      if (k >= 6 && k <= 13) begin
        chk($sformatf("fill.c%0d.i_roff", k), i_roff, k - 6);
        chk($sformatf("fill.c%0d.i_rdata", k), i_rdata, (32'h5670 + 2 * (k - 6)) ^ 32'h5A5A);
      end
      chk($sformatf("fill.c%0d.d_rvalid", k), d_rvalid, 0);
      chk($sformatf("fill.c%0d.i_done", k), i_done, (k == 14));
      chk($sformatf("fill.c%0d.d_done", k), d_done, (k == 20));
      if (k == 0)  i_req = 1'b1;
      if (k == 5)  d_req = 1'b1;
      if (k == 14) i_req = 1'b0;
      if (k == 20) d_req = 1'b0;
      mem_wdone = (k == 19);
    end

    // Memory-side pulses while IDLE must be ignored.
    @(negedge clk);
    stray_v = 1'b1; stray_d = 16'hDEAD; mem_wdone = 1'b1;
    #1;
    chk("idle_stray.i_rvalid", i_rvalid, 0);
    chk("idle_stray.d_rvalid", d_rvalid, 0);
    chk("idle_stray.i_rdata", i_rdata, 0);
    chk("idle_stray.d_rdata", d_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stray_v = 1'b0; mem_wdone = 1'b0;
      chk($sformatf("idle_stray.c%0d.mem_en", k), mem_en, 0);
      chk($sformatf("idle_stray.c%0d.i_done", k), i_done, 0);
      chk($sformatf("idle_stray.c%0d.d_done", k), d_done, 0);
    end

    // D fill at 0x0100 interrupted by reset after three returned words.
    d_we = 1'b0; d_addr = 16'h0100;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rstfill.c%0d.d_rvalid", k), d_rvalid, (k >= 6));
      if (k >= 6) chk($sformatf("rstfill.c%0d.d_roff", k), d_roff, k - 6);
      if (k == 0) d_req = 1'b1;
    end
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk_all_zero("mid_fill_reset");
    for (int k = 9; k <= 14; k++) begin
      @(negedge clk);
      if (k == 9) rst_n = 1'b1;
      chk($sformatf("late.c%0d.d_rvalid", k), d_rvalid, 0);
      chk($sformatf("late.c%0d.i_rvalid", k), i_rvalid, 0);
      chk($sformatf("late.c%0d.mem_en", k), mem_en, 0);
    end

    // Fresh fill after reset starts again at offset 0.
    cnt = 0;
    got = 0;
    d_req = 1'b1;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (d_rvalid) begin
        chk($sformatf("refill.w%0d.d_roff", cnt), d_roff, cnt);
        chk($sformatf("refill.w%0d.d_rdata", cnt), d_rdata, (32'h0100 + 2 * cnt) ^ 32'h5A5A);
        cnt++;
      end
      chk("refill.i_rvalid", i_rvalid, 0);
      if (d_done) begin
        got = 1;
        chk("refill.words", cnt, 8);
        d_req = 1'b0;
      end
    end
    chk("refill.done_seen", got, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
